// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// Operands and result are registered; one operation is in flight at a time.
//
// state | meaning
// IDLE  | no operation in flight, grant offered to the next valid requester from rr_ptr
// EXEC  | operands registered, ALU settling
// RESP  | result held on resp_data, resp_valid raised to the owner until it accepts
module alu_share_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int OPER_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*OPER_WIDTH-1:0]   req_oper,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]              resp_valid,
    input  logic [NUM_REQ-1:0]              resp_ready,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic [OPER_WIDTH-1:0]           alu_oper,
    output logic [DATA_WIDTH-1:0]           alu_a,
    output logic [DATA_WIDTH-1:0]           alu_b,
    input  logic [DATA_WIDTH-1:0]           alu_result
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   cand;
    logic             grant_found;
    logic             accept;
    logic             complete;

    // Rotating priority search; the wrap is an explicit subtract so non-power-of-two counts work.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && grant_found) begin
                    req_ready = NUM_REQ'(1) << grant_idx;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (!rst) begin
                    resp_valid = NUM_REQ'(1) << owner;
                end
                if (resp_ready[owner]) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            alu_oper  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            resp_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_oper <= req_oper[grant_idx*OPER_WIDTH +: OPER_WIDTH];
                alu_a    <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                alu_b    <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                owner    <= grant_idx;
                rr_ptr   <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
            end
            if (state == EXEC) begin
                resp_data <= alu_result;
            end
        end
    end

    logic unused_complete;
    assign unused_complete = complete;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic on a 2-requester
// instance checked every cycle against a transaction-level model, and a 3-requester instance.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_LSL  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd8;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; opcodes 9..15 are reserved and return 0.
    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return {31'b0, $signed(a) < $signed(b)};
            4'd8:    return {31'b0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- two-requester instance ----------------
    logic        rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [7:0]  req_oper;
    logic [63:0] req_a, req_b;
    logic [31:0] resp_data, alu_a, alu_b, alu_result;
    logic [3:0]  alu_oper;

    alu_share_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .OPER_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_oper(req_oper), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
    );
    always_comb alu_result = alu(alu_oper, alu_a, alu_b);

    // ---------------- three-requester instance ----------------
    logic        rst3;
    logic [2:0]  req_valid3, req_ready3, resp_valid3, resp_ready3;
    logic [11:0] req_oper3;
    logic [95:0] req_a3, req_b3;
    logic [31:0] resp_data3, alu_a3, alu_b3, alu_result3;
    logic [3:0]  alu_oper3;

    alu_share_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .OPER_WIDTH(4)) dut3 (
        .clk(clk), .rst(rst3),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_oper(req_oper3), .req_a(req_a3), .req_b(req_b3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
        .alu_oper(alu_oper3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3)
    );
    always_comb alu_result3 = alu(alu_oper3, alu_a3, alu_b3);

    // ---------------- transaction model for the two-requester instance ----------------
    // m_phase counts where the current transaction is: 0 waiting for a grant,
    // 1 the cycle right after acceptance, 2 result offered to the owner.
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_owner = 0;
    bit          m_known = 1'b0;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_rd;

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;
        int g;
        exp_rdy = '0;
        exp_rv  = '0;
        g       = -1;
        if (!rst && m_known) begin
            if (m_phase == 0) begin
                for (int k = 0; k < 2; k++) begin
                    int i;
                    i = (m_ptr + k) % 2;
                    if (g < 0 && req_valid[i]) g = i;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            if (m_phase == 2) exp_rv[m_owner] = 1'b1;
        end
        check("model_req_ready", 64'(req_ready), 64'(exp_rdy));
        check("model_resp_valid", 64'(resp_valid), 64'(exp_rv));
        if (m_known) begin
            check("model_alu_oper", 64'(alu_oper), 64'(m_op));
            check("model_alu_a", 64'(alu_a), 64'(m_a));
            check("model_alu_b", 64'(alu_b), 64'(m_b));
            check("model_resp_data", 64'(resp_data), 64'(m_rd));
        end
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_owner = 0;
            m_op = '0; m_a = '0; m_b = '0; m_rd = '0;
            m_known = 1'b1;
        end else if (m_known) begin
            case (m_phase)
                0: if (g >= 0) begin
                    m_op    = req_oper[g*4 +: 4];
                    m_a     = req_a[g*32 +: 32];
                    m_b     = req_b[g*32 +: 32];
                    m_owner = g;
                    m_ptr   = (g + 1) % 2;
                    m_phase = 1;
                end
                1: begin
                    m_rd    = alu(m_op, m_a, m_b);
                    m_phase = 2;
                end
                default: if (resp_ready[m_owner]) m_phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_oper[i*4 +: 4] = op;
        req_a[i*32 +: 32]  = a;
        req_b[i*32 +: 32]  = b;
    endtask

    task automatic set_req3(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_oper3[i*4 +: 4] = op;
        req_a3[i*32 +: 32]  = a;
        req_b3[i*32 +: 32]  = b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  acc;
        logic [31:0] exp_res [4];
        int          exp_g3  [4];
        rst = 1'b1; req_valid = '0; resp_ready = '0; req_oper = '0; req_a = '0; req_b = '0;
        rst3 = 1'b1; req_valid3 = '0; resp_ready3 = '0; req_oper3 = '0; req_a3 = '0; req_b3 = '0;
        tick(); tick();
        check("reset_resp_data", 64'(resp_data), 64'd0);
        check("reset_alu_a", 64'(alu_a), 64'd0);
        rst = 1'b0;

        // Single op: Add 5+7 from requester 0
        set_req(0, OP_ADD, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        check("single_req_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        #1;
        check("single_exec_no_resp", 64'(resp_valid), 64'(2'b00));
        tick();
        check("single_resp_valid", 64'(resp_valid), 64'(2'b01));
        check("single_resp_data", 64'(resp_data), 64'd12);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        #1;
        check("single_back_to_idle", 64'(resp_valid), 64'(2'b00));

        // Contention from reset: grants alternate 0,1,0,1
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, OP_ADD, 32'd5, 32'd7);
        set_req(1, OP_SUB, 32'd10, 32'd3);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int n = 0; n < 4; n++) begin
            logic [1:0] oh;
            oh = (n % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check("contend_grant", 64'(req_ready), 64'(oh));
            tick();
            tick();
            check("contend_owner", 64'(resp_valid), 64'(oh));
            check("contend_data", 64'(resp_data), (n % 2 == 0) ? 64'd12 : 64'd7);
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 2'b00;

        // Back-pressure: owner 0 holds off for 5 cycles, requester 1 waits
        set_req(0, OP_ADD, 32'd5, 32'd7);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        set_req(1, OP_ADD, 32'd1, 32'd2);
        tick();
        for (int n = 0; n < 5; n++) begin
            check("bp_resp_valid", 64'(resp_valid), 64'(2'b01));
            check("bp_resp_data", 64'(resp_data), 64'd12);
            check("bp_req_ready", 64'(req_ready), 64'(2'b00));
            tick();
        end
        resp_ready = 2'b01;
        req_valid  = 2'b00;
        tick();
        resp_ready = 2'b00;
        #1;
        check("bp_done", 64'(resp_valid), 64'(2'b00));

        // Non-owner ready does not complete owner 1's response
        req_valid = 2'b10;
        set_req(1, OP_ADD, 32'd1, 32'd2);
        #1;
        check("nonowner_grant", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        resp_ready = 2'b01;
        tick();
        for (int n = 0; n < 3; n++) begin
            check("nonowner_hold", 64'(resp_valid), 64'(2'b10));
            check("nonowner_data", 64'(resp_data), 64'd3);
            tick();
        end
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;
        #1;
        check("nonowner_done", 64'(resp_valid), 64'(2'b00));

        // Reset while in RESP discards the op and clears rr_ptr
        set_req(0, OP_SUB, 32'd9, 32'd4);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        check("rstresp_pre", 64'(resp_valid), 64'(2'b01));
        rst = 1'b1;
        #1;
        check("rstresp_during", 64'(resp_valid), 64'(2'b00));
        tick();
        rst = 1'b0;
        #1;
        check("rstresp_after", 64'(resp_valid), 64'(2'b00));
        check("rstresp_alu_a", 64'(alu_a), 64'd0);
        req_valid = 2'b11;
        #1;
        check("rstresp_ptr_zero", 64'(req_ready), 64'(2'b01));
        req_valid = 2'b10;
        set_req(1, OP_SUB, 32'd10, 32'd3);
        #1;
        check("rstresp_req1_grant", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        resp_ready = 2'b10;
        tick();
        check("rstresp_req1_resp", 64'(resp_valid), 64'(2'b10));
        check("rstresp_req1_data", 64'(resp_data), 64'd7);
        tick();
        resp_ready = 2'b00;

        // Randomized traffic; the negedge model checks every cycle
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            resp_ready = 2'($urandom);
            #1;
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_valid[i] = 1'b1;
                        set_req(i, 4'($urandom_range(0, 15)), $urandom,
                                ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0; req_valid = '0; resp_ready = '0;

        // Three requesters, all valid: grant order 0,1,2,0
        tick();
        rst3 = 1'b0;
        set_req3(0, OP_LSL,  32'd1, 32'd31);
        set_req3(1, OP_SLTU, 32'd1, 32'd2);
        set_req3(2, OP_ADD,  32'd3, 32'd4);
        req_valid3  = 3'b111;
        resp_ready3 = 3'b111;
        exp_g3  = '{0, 1, 2, 0};
        exp_res = '{32'h8000_0000, 32'd1, 32'd7, 32'h8000_0000};
        for (int n = 0; n < 4; n++) begin
            logic [2:0] oh;
            oh = 3'b001 << exp_g3[n];
            #1;
            check("n3_grant", 64'(req_ready3), 64'(oh));
            tick();
            tick();
            check("n3_owner", 64'(resp_valid3), 64'(oh));
            check("n3_data", 64'(resp_data3), 64'(exp_res[n]));
            tick();
        end
        // rr_ptr is now 1: requesters 0 and 2 valid -> 2, then wrap to 0
        req_valid3 = 3'b101;
        #1;
        check("n3_skip_grant", 64'(req_ready3), 64'(3'b100));
        tick(); tick(); tick();
        #1;
        check("n3_wrap_grant", 64'(req_ready3), 64'(3'b001));
        tick(); tick();
        check("n3_wrap_data", 64'(resp_data3), 64'h8000_0000);
        tick();
        req_valid3 = '0;
        resp_ready3 = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
